// File: rtl/memoria_instrucoes.sv
// memoria_instrucoes: 16 x 16-bit instruction memory with a registered read port.
// Define INSTR_MEM_WRITE_EN to build the writable RAM variant; otherwise it is a fixed-image ROM.
module memoria_instrucoes #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Wren,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] IMAGE_BASE = DATA_WIDTH'(16'hA000);

    // Program image: every word is the base opcode with its own address in the low bits.
    function automatic logic [DATA_WIDTH-1:0] image_word(input logic [ADDR_WIDTH-1:0] addr);
        return IMAGE_BASE | DATA_WIDTH'(addr);
    endfunction

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

`ifdef INSTR_MEM_WRITE_EN

    logic [DATA_WIDTH-1:0] rd_word [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_q;
            logic [DATA_WIDTH-1:0] word_d;

            // Reset reloads the image and takes priority over a write on the same edge.
            always_comb begin
                word_d = word_q;
                if (Reset) begin
                    word_d = image_word(ADDR_WIDTH'(gi));
                end else if (Wren && (Address == ADDR_WIDTH'(gi))) begin
                    word_d = Din;
                end
            end

            always_ff @(posedge Clock) begin
                word_q <= word_d;
            end

            assign rd_word[gi] = word_q;
        end
    endgenerate

    // Write-first: the word being written is what appears on Q at the write edge.
    always_comb begin
        q_d = rd_word[Address];
        if (Reset) begin
            q_d = '0;
        end else if (Wren) begin
            q_d = Din;
        end
    end

`else

    // Contents are fixed, so the read is just the image word; Wren and Din are ignored.
    logic unused_rom_inputs;
    assign unused_rom_inputs = ^{Wren, Din};

    always_comb begin
        q_d = image_word(Address);
        if (Reset) begin
            q_d = '0;
        end
    end

`endif

    always_ff @(posedge Clock) begin
        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: tb/tb_memoria_instrucoes.sv
// Directed self-checking bench for memoria_instrucoes (ROM build by default,
// write-path vectors added when INSTR_MEM_WRITE_EN is defined).
module tb_memoria_instrucoes;

    logic        clk;
    logic        reset;
    logic        wren;
    logic [3:0]  address;
    logic [15:0] din;
    logic [15:0] q;

    int tests_run;
    int tests_failed;

    memoria_instrucoes #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4)
    ) dut (
        .Clock  (clk),
        .Reset  (reset),
        .Wren   (wren),
        .Address(address),
        .Din    (din),
        .Q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: Q=%h", tag, got);
        end
    endtask

    // Present inputs away from the edge, clock once, then sample just after the edge.
    task automatic cycle(input logic rst, input logic we, input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        reset   = rst;
        wren    = we;
        address = addr;
        din     = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        wren    = 1'b0;
        address = 4'd0;
        din     = 16'h0000;

        // Reset, then first read
        cycle(1'b1, 1'b0, 4'd3, 16'h0000);
        check_value("reset_q_zero", q, 16'h0000);
        cycle(1'b0, 1'b0, 4'd3, 16'h0000);
        check_value("read_after_reset_a3", q, 16'hA003);

        // Q holds between edges
        @(negedge clk);
        address = 4'd9;
        #2;
        check_value("q_holds_between_edges", q, 16'hA003);

        // Sequential read 0..15 then wrap to 0
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b0, 4'(i), 16'h0000);
            check_value($sformatf("seq_read_%0d", i % 16), q, 16'hA000 + 16'(i % 16));
        end

        // Reset has priority over a write
        cycle(1'b1, 1'b1, 4'd2, 16'hFFFF);
        check_value("reset_priority_q", q, 16'h0000);
        cycle(1'b0, 1'b0, 4'd2, 16'h0000);
        check_value("reset_priority_read_a2", q, 16'hA002);

`ifdef INSTR_MEM_WRITE_EN
        cycle(1'b0, 1'b1, 4'd7, 16'h1234);
        check_value("write_first_a7", q, 16'h1234);
        cycle(1'b0, 1'b0, 4'd7, 16'h0000);
        check_value("read_back_a7", q, 16'h1234);
        cycle(1'b0, 1'b0, 4'd6, 16'h0000);
        check_value("neighbour_a6", q, 16'hA006);
        cycle(1'b0, 1'b1, 4'd15, 16'h5A5A);
        check_value("write_first_a15", q, 16'h5A5A);
        cycle(1'b0, 1'b0, 4'd15, 16'h0000);
        check_value("read_back_a15", q, 16'h5A5A);
        cycle(1'b1, 1'b0, 4'd7, 16'h0000);
        check_value("reset_after_write_q", q, 16'h0000);
        cycle(1'b0, 1'b0, 4'd7, 16'h0000);
        check_value("reset_restores_a7", q, 16'hA007);
        cycle(1'b0, 1'b0, 4'd15, 16'h0000);
        check_value("reset_restores_a15", q, 16'hA00F);
`else
        cycle(1'b0, 1'b1, 4'd4, 16'hBEEF);
        check_value("rom_write_edge_a4", q, 16'hA004);
        cycle(1'b0, 1'b0, 4'd4, 16'h0000);
        check_value("rom_read_a4", q, 16'hA004);
        cycle(1'b0, 1'b1, 4'd0, 16'h0000);
        check_value("rom_write_edge_a0", q, 16'hA000);
        cycle(1'b0, 1'b0, 4'd0, 16'h0000);
        check_value("rom_read_a0", q, 16'hA000);
`endif

        // Mid-stream reset followed by a read at the top address
        cycle(1'b1, 1'b0, 4'd15, 16'h0000);
        check_value("midstream_reset_q", q, 16'h0000);
        cycle(1'b0, 1'b0, 4'd15, 16'h0000);
        check_value("read_after_midstream_a15", q, 16'hA00F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
